// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared types and helpers for the systolic matrix-multiplier processing
// elements:
//   - pe_state_e : accumulator FSM states (IDLE = empty, ACC = partial sum held)
//   - ERR_*      : bit positions inside the sticky err vector
//   - sat_add()  : width-generic add with overflow detect and optional clamp
// -----------------------------------------------------------------------------
package systolic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } pe_state_e;

  localparam int ERR_OVWR = 0;  // result overwritten before it was drained
  localparam int ERR_VMIS = 1;  // a_vld_in and b_vld_in disagreed
  localparam int ERR_SAT  = 2;  // accumulation clamped

  // Widest accumulator sat_add() supports.
  localparam int ADD_MAX_W = 64;

  typedef struct packed {
    logic [ADD_MAX_W-1:0] sum;  // w-bit result in the low bits, upper bits zero
    logic                 ovf;  // true overflow of the w-bit add
  } add_res_t;

  // Adds the low w bits of a and b. Overflow is detected for the selected
  // arithmetic; when sat_en is set an overflowing sum is replaced by the
  // nearest representable bound. w must be a constant in [1, ADD_MAX_W].
  function automatic add_res_t sat_add(input logic [ADD_MAX_W-1:0] a,
                                       input logic [ADD_MAX_W-1:0] b,
                                       input int                   w,
                                       input logic                 signed_mode,
                                       input logic                 sat_en);
    logic [ADD_MAX_W-1:0] mask;
    logic [ADD_MAX_W-1:0] msb;
    logic [ADD_MAX_W:0]   full;
    logic [ADD_MAX_W-1:0] sum;
    logic [ADD_MAX_W-1:0] clamp;
    logic                 a_neg;
    logic                 b_neg;
    logic                 s_neg;
    logic                 ovf;
    add_res_t             res;

    // Shifting by the full width yields 0, so w == ADD_MAX_W gives all ones.
    mask  = (ADD_MAX_W'(1) << w) - ADD_MAX_W'(1);
    msb   = ADD_MAX_W'(1) << (w - 1);
    full  = {1'b0, a & mask} + {1'b0, b & mask};
    sum   = full[ADD_MAX_W-1:0] & mask;
    a_neg = (a & msb) != '0;
    b_neg = (b & msb) != '0;
    s_neg = (sum & msb) != '0;

    if (signed_mode) begin
      // Two's complement overflow: equal operand signs, different result sign.
      ovf   = (a_neg == b_neg) && (s_neg != a_neg);
      clamp = a_neg ? msb : (mask & ~msb);
    end else begin
      // Unsigned overflow: carry out of bit w-1.
      ovf   = (full >> w) != '0;
      clamp = mask;
    end

    res.sum = (sat_en && ovf) ? clamp : sum;
    res.ovf = ovf;
    return res;
  endfunction

endpackage

// File: rtl/pe_acc_add.sv
// -----------------------------------------------------------------------------
// pe_acc_add
// ACC_W-bit accumulator adder. Wraps modulo 2^ACC_W by default; with
// SYSTOLIC_PE_SAT_EN defined it clamps to the signed or unsigned range and
// raises flag whenever a clamp happens (flag is always 0 otherwise).
//
// Parameters: ACC_W  adder width (<= systolic_pkg::ADD_MAX_W)
//             SIGNED 1 = two's complement, 0 = unsigned
// Ports:      a, b   addends
//             sum    result (wrapped or clamped)
//             flag   clamp applied this cycle
// -----------------------------------------------------------------------------
module pe_acc_add
  import systolic_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int SIGNED = 0
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             flag
);

`ifdef SYSTOLIC_PE_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  add_res_t             res;
  logic [ADD_MAX_W-1:0] unused_sum;

  always_comb begin
    res = sat_add(ADD_MAX_W'(a), ADD_MAX_W'(b), ACC_W, (SIGNED != 0), SAT_EN);
  end

  assign sum        = res.sum[ACC_W-1:0];
  assign flag       = res.ovf & SAT_EN;
  assign unused_sum = res.sum;

endmodule

// File: rtl/systolic_pe.sv
// -----------------------------------------------------------------------------
// systolic_pe
// Output-stationary processing element. Operand A moves right and operand B
// moves down through one register stage each, with their valid/last tags.
// Matched beats are multiplied and accumulated; the last beat of a dot product
// hands the sum and beat count to a result register drained by valid/ready.
// Errors (overwrite, valid mismatch, saturation) are sticky until err_clr/rst.
//
// Optional feature: define SYSTOLIC_PE_SAT_EN for saturating accumulation
// (otherwise the accumulator wraps and err[2] is tied to 0).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   a_in, a_vld_in, a_last_in operand A with valid and end-of-dot-product tag
//   b_in, b_vld_in            operand B with valid
//   a_out, a_vld_out, a_last_out / b_out, b_vld_out   registered pass-through
//   res_data, res_cnt, res_vld, res_rdy               result drain handshake
//   err, err_clr              sticky flags [0] ovwr [1] vld mismatch [2] sat
// -----------------------------------------------------------------------------
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,  // must be >= 2*DATA_W
  parameter int CNT_W  = 16,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  input  logic              a_last_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_vld_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  output logic              a_last_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_vld_out,
  output logic [ACC_W-1:0]  res_data,
  output logic [CNT_W-1:0]  res_cnt,
  output logic              res_vld,
  input  logic              res_rdy,
  output logic [2:0]        err,
  input  logic              err_clr
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              a_vld_q, a_vld_d, a_last_q, a_last_d, b_vld_q, b_vld_d;
  pe_state_e         state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  res_data_q, res_data_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
  logic              res_vld_q, res_vld_d;
  logic [2:0]        err_q, err_d;

  // ---------------------------------------------------------------------------
  // Product, extended to the accumulator width
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] prod_ext;

  if (SIGNED != 0) begin : g_prod_signed
    logic signed [2*DATA_W-1:0] prod;
    assign prod     = $signed({{DATA_W{a_in[DATA_W-1]}}, a_in}) *
                      $signed({{DATA_W{b_in[DATA_W-1]}}, b_in});
    assign prod_ext = ACC_W'(prod);  // signed cast sign-extends
  end else begin : g_prod_unsigned
    logic [2*DATA_W-1:0] prod;
    assign prod     = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
    assign prod_ext = ACC_W'(prod);
  end

  // ---------------------------------------------------------------------------
  // Accumulator adder: from IDLE the product starts a fresh sum
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] sum;
  logic             sat_flag;

  assign add_a = (state_q == ACC) ? acc_q : '0;

  pe_acc_add #(
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_acc_add (
    .a    (add_a),
    .b    (prod_ext),
    .sum  (sum),
    .flag (sat_flag)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic       beat;
  logic       mismatch;
  logic       load;
  logic [2:0] err_set;

  assign beat     = a_vld_in & b_vld_in;
  assign mismatch = a_vld_in ^ b_vld_in;
  assign load     = beat & a_last_in;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_cnt_d  = res_cnt_q;
    res_vld_d  = res_vld_q & ~res_rdy;  // drain on transfer
    err_set    = '0;

    // Pass-through stage copies inputs unconditionally.
    a_d      = a_in;
    a_vld_d  = a_vld_in;
    a_last_d = a_last_in;
    b_d      = b_in;
    b_vld_d  = b_vld_in;

    if (beat) begin
      if (load) begin
        // Final sum goes straight to the result; accumulator is free again on
        // the next cycle, so back-to-back dot products need no bubble.
        state_d    = IDLE;
        acc_d      = '0;
        cnt_d      = '0;
        res_data_d = sum;
        res_cnt_d  = (state_q == ACC) ? cnt_q + CNT_W'(1) : CNT_W'(1);
        res_vld_d  = 1'b1;
      end else begin
        state_d = ACC;
        acc_d   = sum;
        cnt_d   = (state_q == ACC) ? cnt_q + CNT_W'(1) : CNT_W'(1);
      end
    end

    err_set[ERR_OVWR] = load & res_vld_q & ~res_rdy;
    err_set[ERR_VMIS] = mismatch;
`ifdef SYSTOLIC_PE_SAT_EN
    err_set[ERR_SAT]  = beat & sat_flag;
`else
    err_set[ERR_SAT]  = 1'b0;
`endif

    // Set wins over a simultaneous clear.
    err_d = (err_q & ~{3{err_clr}}) | err_set;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      a_q        <= '0;
      a_vld_q    <= 1'b0;
      a_last_q   <= 1'b0;
      b_q        <= '0;
      b_vld_q    <= 1'b0;
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_cnt_q  <= '0;
      res_vld_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      a_q        <= a_d;
      a_vld_q    <= a_vld_d;
      a_last_q   <= a_last_d;
      b_q        <= b_d;
      b_vld_q    <= b_vld_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_cnt_q  <= res_cnt_d;
      res_vld_q  <= res_vld_d;
      err_q      <= err_d;
    end
  end

  assign a_out      = a_q;
  assign a_vld_out  = a_vld_q;
  assign a_last_out = a_last_q;
  assign b_out      = b_q;
  assign b_vld_out  = b_vld_q;
  assign res_data   = res_data_q;
  assign res_cnt    = res_cnt_q;
  assign res_vld    = res_vld_q;
  assign err        = err_q;

endmodule

// File: tb/tb_systolic_pe.sv
// -----------------------------------------------------------------------------
// tb_systolic_pe
// Directed bench for systolic_pe. Three instances share one stimulus stream:
//   u_u : DATA_W=8, ACC_W=32, unsigned
//   u_s : DATA_W=8, ACC_W=32, signed
//   u_n : DATA_W=8, ACC_W=16, unsigned (wrap / saturation corner)
// Inputs change 1 time unit after the rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_systolic_pe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_in, b_in;
  logic       a_vld_in, b_vld_in, a_last_in;
  logic       res_rdy, err_clr;

  logic [7:0]  uu_a_out, uu_b_out, us_a_out, us_b_out, un_a_out, un_b_out;
  logic        uu_a_vld, uu_b_vld, uu_a_last;
  logic        us_a_vld, us_b_vld, us_a_last;
  logic        un_a_vld, un_b_vld, un_a_last;
  logic [31:0] uu_res_data, us_res_data;
  logic [15:0] un_res_data;
  logic [15:0] uu_res_cnt, us_res_cnt, un_res_cnt;
  logic        uu_res_vld, us_res_vld, un_res_vld;
  logic [2:0]  uu_err, us_err, un_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_pe #(.DATA_W(8), .ACC_W(32), .CNT_W(16), .SIGNED(0)) u_u (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_vld_in(a_vld_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_vld_in(b_vld_in),
    .a_out(uu_a_out), .a_vld_out(uu_a_vld), .a_last_out(uu_a_last),
    .b_out(uu_b_out), .b_vld_out(uu_b_vld),
    .res_data(uu_res_data), .res_cnt(uu_res_cnt), .res_vld(uu_res_vld),
    .res_rdy(res_rdy), .err(uu_err), .err_clr(err_clr)
  );

  systolic_pe #(.DATA_W(8), .ACC_W(32), .CNT_W(16), .SIGNED(1)) u_s (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_vld_in(a_vld_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_vld_in(b_vld_in),
    .a_out(us_a_out), .a_vld_out(us_a_vld), .a_last_out(us_a_last),
    .b_out(us_b_out), .b_vld_out(us_b_vld),
    .res_data(us_res_data), .res_cnt(us_res_cnt), .res_vld(us_res_vld),
    .res_rdy(res_rdy), .err(us_err), .err_clr(err_clr)
  );

  systolic_pe #(.DATA_W(8), .ACC_W(16), .CNT_W(16), .SIGNED(0)) u_n (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_vld_in(a_vld_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_vld_in(b_vld_in),
    .a_out(un_a_out), .a_vld_out(un_a_vld), .a_last_out(un_a_last),
    .b_out(un_b_out), .b_vld_out(un_b_vld),
    .res_data(un_res_data), .res_cnt(un_res_cnt), .res_vld(un_res_vld),
    .res_rdy(res_rdy), .err(un_err), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of operand inputs, then step to just after the next edge.
  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic va, input logic vb, input logic last);
    a_in      = a;
    b_in      = b;
    a_vld_in  = va;
    b_vld_in  = vb;
    a_last_in = last;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; res_rdy = 1'b0; err_clr = 1'b0;
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check("rst_a_out",    uu_a_out,    0);
    check("rst_res_vld",  uu_res_vld,  0);
    check("rst_res_data", uu_res_data, 0);
    check("rst_err",      uu_err,      0);
    rst = 1'b0;

    // Unsigned dot product 3*4 + 5*6 + 7*8 = 98.
    res_rdy = 1'b1;
    drive(8'd3, 8'd4, 1'b1, 1'b1, 1'b0);
    check("pass_a_out", uu_a_out, 3);
    check("pass_b_out", uu_b_out, 4);
    check("pass_a_vld", uu_a_vld, 1);
    drive(8'd5, 8'd6, 1'b1, 1'b1, 1'b0);
    check("pass_a_out2", uu_a_out, 5);
    check("u_vld_early", uu_res_vld, 0);
    drive(8'd7, 8'd8, 1'b1, 1'b1, 1'b1);
    check("u_res_vld",  uu_res_vld,  1);
    check("u_res_data", uu_res_data, 98);
    check("u_res_cnt",  uu_res_cnt,  3);
    check("pass_last",  uu_a_last,   1);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check("u_drain",    uu_res_vld,  0);
    check("pass_vld0",  uu_a_vld,    0);

    // Signed: (-128)(-128) + 127(-1) = 16257, then (-2)(3) = -6 back to back.
    drive(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
    drive(8'h7F, 8'hFF, 1'b1, 1'b1, 1'b1);
    check("s_res_data1", us_res_data, 16257);
    check("s_res_cnt1",  us_res_cnt,  2);
    drive(8'hFE, 8'h03, 1'b1, 1'b1, 1'b1);
    check("s_res_data2", us_res_data, 32'hFFFF_FFFA);
    check("s_res_cnt2",  us_res_cnt,  1);
    check("s_res_vld2",  us_res_vld,  1);
    check("s_no_ovwr",   us_err[0],   0);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Overwrite with res_rdy low.
    res_rdy = 1'b0;
    drive(8'd1, 8'd2, 1'b1, 1'b1, 1'b1);
    check("ow_first",    uu_res_data, 2);
    check("ow_err_pre",  uu_err,      0);
    drive(8'd3, 8'd3, 1'b1, 1'b1, 1'b1);
    check("ow_second",   uu_res_data, 9);
    check("ow_err",      uu_err,      3'b001);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check("ow_hold",     uu_res_data, 9);
    check("ow_hold_vld", uu_res_vld,  1);
    err_clr = 1'b1;
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    check("ow_clr",      uu_err,      0);
    // Same load while a transfer happens on that edge: no overwrite.
    res_rdy = 1'b1;
    drive(8'd4, 8'd4, 1'b1, 1'b1, 1'b1);
    check("xfer_data",   uu_res_data, 16);
    check("xfer_err",    uu_err,      0);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check("xfer_drain",  uu_res_vld,  0);

    // Valid mismatch mid-accumulation: 2*3 + (skipped 9) + 4*5 = 26.
    drive(8'd2, 8'd3, 1'b1, 1'b1, 1'b0);
    drive(8'd9, 8'd9, 1'b1, 1'b0, 1'b0);
    check("mis_err",     uu_err,      3'b010);
    check("mis_a_vld",   uu_a_vld,    1);
    check("mis_b_vld",   uu_b_vld,    0);
    drive(8'd4, 8'd5, 1'b1, 1'b1, 1'b1);
    check("mis_sum",     uu_res_data, 26);
    check("mis_cnt",     uu_res_cnt,  2);
    err_clr = 1'b1;
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    check("mis_clr",     uu_err,      0);

    // ACC_W=16 corner: 255*255*2 = 130050.
    drive(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
    drive(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
`ifdef SYSTOLIC_PE_SAT_EN
    check("n_sat_data",  un_res_data, 65535);
    check("n_sat_err",   un_err[2],   1);
`else
    check("n_wrap_data", un_res_data, 64514);
    check("n_wrap_err",  un_err[2],   0);
`endif
    check("n_cnt",       un_res_cnt,  2);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-accumulation with a pending result.
    res_rdy = 1'b0;
    drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b1);
    drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
    drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check("rst2_res_vld",  uu_res_vld,  0);
    check("rst2_res_data", uu_res_data, 0);
    check("rst2_res_cnt",  uu_res_cnt,  0);
    check("rst2_a_out",    uu_a_out,    0);
    check("rst2_err",      uu_err,      0);
    rst = 1'b0;
    res_rdy = 1'b1;
    drive(8'd2, 8'd2, 1'b1, 1'b1, 1'b1);
    check("rst2_sum", uu_res_data, 4);
    check("rst2_cnt", uu_res_cnt,  1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
